// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_pkg : shared types and constants for the radix-4 sequential divider     |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
package div_pkg;

    localparam int c_n_default = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Two quotient bits are resolved per iteration.
    function automatic int iter_count(input int n);
        return n / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_r4_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_r4_step : one radix-4 restoring step, picks digit k in 0..3 and t-k*b   |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
module div_r4_step #(
    parameter int N = 8
) (
    input  logic [N+1:0] i_t,
    input  logic [N-1:0] i_b,
    input  logic [N+1:0] i_d3,
    output logic [1:0]   o_digit,
    output logic [N-1:0] o_rem_next
);

    logic [N+1:0] w_b1;
    logic [N+1:0] w_b2;
    logic [N+1:0] w_sub;

    assign w_b1 = {2'b00, i_b};
    assign w_b2 = {1'b0, i_b, 1'b0};

    always_comb begin
        o_digit = 2'd0;
        w_sub   = '0;
        if (i_t >= i_d3) begin
            o_digit = 2'd3;
            w_sub   = i_d3;
        end else if (i_t >= w_b2) begin
            o_digit = 2'd2;
            w_sub   = w_b2;
        end else if (i_t >= w_b1) begin
            o_digit = 2'd1;
            w_sub   = w_b1;
        end
    end

    // The true difference is below b, so only the low N bits are meaningful.
    assign o_rem_next = i_t[N-1:0] - w_sub[N-1:0];

endmodule
`default_nettype wire

// File: rtl/div16_8_r4_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div16_8_r4_seq : 2N/N unsigned radix-4 sequential divider, valid/ready I/O  |
// | Optional macro DIV_ERR_CHECK_EN enables divide-by-zero / overflow early exit|
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
module div16_8_r4_seq
    import div_pkg::*;
#(
    parameter int N = c_n_default
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] p,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int c_iters = iter_count(N);
    localparam int c_cw    = (c_iters > 1) ? $clog2(c_iters) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_iters - 1);

    div_state_e r_state;
    div_state_e w_next;

    logic [2*N-1:0] r_p;
    logic [N-1:0]   r_b;
    logic [N+1:0]   r_d3;
    logic [N-1:0]   r_rem;
    logic [N-1:0]   r_lo;
    logic [N-1:0]   r_q;
    logic [c_cw-1:0] r_cnt;

    logic [N+1:0]   w_d3;
    logic [N+1:0]   w_t;
    logic [1:0]     w_digit;
    logic [N-1:0]   w_rem_next;
    logic           w_err;
    logic           w_last;

    assign w_d3   = {2'b00, r_b} + {1'b0, r_b, 1'b0};
    assign w_t    = {r_rem, r_lo[N-1:N-2]};
    assign w_last = (r_cnt == c_last);

`ifdef DIV_ERR_CHECK_EN
    logic w_dz;
    logic w_ov;
    logic r_dz;
    logic r_ov;

    assign w_dz  = (r_b == '0);
    assign w_ov  = !w_dz && (r_p[2*N-1:N] >= r_b);
    assign w_err = w_dz || w_ov;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;
`else
    assign w_err       = 1'b0;
    assign div_by_zero = 1'b0;
    assign overflow    = 1'b0;
`endif

    div_r4_step #(.N(N)) u_step (
        .i_t        (w_t),
        .i_b        (r_b),
        .i_d3       (r_d3),
        .o_digit    (w_digit),
        .o_rem_next (w_rem_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = PREP;
            PREP:    w_next = w_err ? DONE : ITER;
            ITER:    if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_b   <= '0;
            r_d3  <= '0;
            r_rem <= '0;
            r_lo  <= '0;
            r_q   <= '0;
            r_cnt <= '0;
`ifdef DIV_ERR_CHECK_EN
            r_dz  <= 1'b0;
            r_ov  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_p <= p;
                        r_b <= b;
                    end
                end
                PREP: begin
                    r_d3  <= w_d3;
                    r_rem <= r_p[2*N-1:N];
                    r_lo  <= r_p[N-1:0];
                    r_cnt <= '0;
`ifdef DIV_ERR_CHECK_EN
                    r_dz  <= w_dz;
                    r_ov  <= w_ov;
                    // Error results overwrite the initial remainder load.
                    if (w_dz) begin
                        r_q   <= '1;
                        r_rem <= r_p[N-1:0];
                    end else if (w_ov) begin
                        r_q   <= '1;
                        r_rem <= '0;
                    end
`endif
                end
                ITER: begin
                    r_rem <= w_rem_next;
                    r_lo  <= {r_lo[N-3:0], 2'b00};
                    r_q   <= {r_q[N-3:0], w_digit};
                    r_cnt <= r_cnt + c_cw'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign q         = r_q;
    assign r         = r_rem;

endmodule
`default_nettype wire

// File: doc/div16_8_r4_seq.md
# div16_8_r4_seq

Sequential radix-4 unsigned divider, the inverse of the 8x8 multiplier datapath: takes a 16-bit product-width dividend P and an 8-bit divisor B and returns an 8-bit quotient Q and an 8-bit remainder R with P = Q*B + R. It resolves 2 quotient bits per cycle, matching the 2-bit partitioning of the multiplier family. It uses valid/ready handshakes on both sides and sits downstream of the multiplier blocks for round-trip checking and normalisation paths.

## Interface
- N, default 8: quotient, divisor and remainder width; the dividend is 2N. N must be even.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block idle and accepting.
- p  input  2N  dividend.
- b  input  N  divisor.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- q  output  N  quotient.
- r  output  N  remainder.
- div_by_zero  output  1  b was 0.
- overflow  output  1  quotient does not fit in N bits (p[2N-1:N] >= b, b != 0).

## Operation
- FSM states: IDLE, PREP, ITER, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, register p and b, then go to PREP.
- PREP:
  - Compute and register d3 = 3*b (N+2 bits).
  - Initialise the partial remainder rem = p[2N-1:N] and the low shift register lo = p[N-1:0].
  - Clear the iteration counter.
  - Check errors. If either error is detected, go straight to DONE.
  - Otherwise go to ITER.
- ITER, N/2 cycles. Each cycle:
  - Form t = {rem, lo[N-1:N-2]} (N+2 bits).
  - Select digit k in 0..3 as the largest k with k*b <= t, comparing against b, 2b and d3.
  - Update rem = t - k*b; truncation to N bits is exact.
  - Shift lo left by 2 and shift k into q.
  - After the last iteration, go to DONE.
- DONE:
  - out_valid = 1. q, r and the flags are held stable until out_ready.
  - On out_ready, go to IDLE.
- Error results:
  - b == 0: q = all ones, r = p[N-1:0], div_by_zero = 1, overflow = 0.
  - Overflow: q = all ones, r = 0, overflow = 1, div_by_zero = 0.
- in_ready is 0 in PREP, ITER and DONE. in_valid is ignored there, and no input is accepted in the cycle DONE exits.
- Arithmetic is unsigned throughout. The comparison and subtraction width is N+2.

## Timing
- Reset values: in_ready = 1, out_valid = 0, q = 0, r = 0, div_by_zero = 0, overflow = 0, FSM in IDLE.
- Accept edge = cycle 0. PREP occupies cycle 1 and ITER occupies cycles 2..N/2+1.
- Normal case: out_valid rises at cycle N/2+2, which is cycle 6 for N = 8.
- Error case: out_valid rises at cycle 2.
- Output handshake at cycle k: out_valid = 0 and in_ready = 1 at cycle k+1.
- Maximum throughput is one division per N/2+3 cycles.
- rst_n low in any state returns the block to IDLE on the next edge. All outputs take their reset values and any in-flight or unconsumed result is discarded.
- Outputs are registered; there is no combinational path from inputs to outputs except in_ready, which is a function of state only.

## Configuration
- DIV_ERR_CHECK_EN:
  - Defined: PREP performs the zero and overflow checks, drives the flags, and takes the early DONE exit with the error results above.
  - Undefined: no checks, div_by_zero and overflow are tied 0, and every operation runs all N/2 iterations. q and r are unspecified for b = 0 or overflow inputs, but latency is still N/2+2 and the block must never hang.

## Structure
- Package div_pkg holds:
  - typedef enum for the FSM states (IDLE, PREP, ITER, DONE);
  - localparam for the default N;
  - a function giving the iteration count N/2.
- One combinational sub-module, div_r4_step:
  - inputs: t, b, d3;
  - outputs: the 2-bit digit and the next remainder.
- The top level holds the FSM, the registers and the handshake logic.

## Test plan
- Normal: p = 0x3039, b = 0x7B -> q = 0x64, r = 0x2D, flags 0, out_valid exactly 6 cycles after accept.
- Maximum: p = 0xFE01, b = 0xFF -> q = 0xFF, r = 0x00.
- Divide by zero (DIV_ERR_CHECK_EN): p = 0x1234, b = 0x00 -> div_by_zero = 1, q = 0xFF, r = 0x34, out_valid 2 cycles after accept.
- Overflow (DIV_ERR_CHECK_EN): p = 0x8000, b = 0x80 -> overflow = 1, q = 0xFF, r = 0x00.
- Backpressure: out_ready held low 5 cycles in DONE -> q, r and out_valid stable and in_ready = 0. After the handshake, in_ready = 1 on the next cycle, and a new op (p = 0x0064, b = 0x0A -> q = 0x0A, r = 0) completes correctly.
- Reset mid-ITER: rst_n low for one cycle during iteration 2 -> next cycle out_valid = 0, in_ready = 1, all outputs 0. The following op p = 0x3039, b = 0x7B gives correct results.
